// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU data-memory interface.
package cpu_mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Error classification; the external interface only exposes "nonzero".
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE    = 2'd2;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// Byte-enabled synchronous-write RAM with a registered read port; contents are never reset.
module mem_word_array
  import cpu_mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [BE_W-1:0]       wbe,
  input  logic [WORD_W-1:0]     wdata,
  input  logic                  re,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < BE_W; i++) begin
      if (wbe[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Data-memory responder: valid/ready request, WAIT_CYCLES wait states, then a
// single-cycle response pulse carrying load data or an error flag.
module mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [BE_W-1:0]   req_be,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam logic [32:0] SPAN      = 33'd4 << DEPTH_LOG2;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic        NO_WAIT   = (WAIT_CYCLES == 0);

  state_t              state;
  logic [3:0]          cnt;
  logic                lat_we;
  logic [31:0]         lat_addr;
  logic [BE_W-1:0]     lat_be;
  logic [WORD_W-1:0]   lat_wdata;
  logic                load_q;

  logic                eff_we;
  logic [31:0]         eff_addr;
  logic [BE_W-1:0]     eff_be;
  logic [WORD_W-1:0]   eff_wdata;
  logic [31:0]         off;
  logic [1:0]          err_code;
  logic                accept;
  logic                go_resp;
  logic [BE_W-1:0]     ram_wbe;
  logic                ram_re;
  logic [WORD_W-1:0]   ram_rdata;

  // With no wait states the commit happens on the accept edge itself, so the
  // live request stands in for the not-yet-latched copy while in IDLE.
  always_comb begin
    eff_we    = lat_we;
    eff_addr  = lat_addr;
    eff_be    = lat_be;
    eff_wdata = lat_wdata;
    if (state == S_IDLE) begin
      eff_we    = req_we;
      eff_addr  = req_addr;
      eff_be    = req_be;
      eff_wdata = req_wdata;
    end
  end

  always_comb begin
    off      = eff_addr - BASE_ADDR;
    err_code = ERR_NONE;
    if (!word_aligned(eff_addr[1:0]))
      err_code = ERR_MISALIGN;
    else if (eff_addr < BASE_ADDR || {1'b0, off} >= SPAN)
      err_code = ERR_RANGE;
  end

  assign accept  = req_valid && req_ready;
  assign go_resp = (accept && NO_WAIT) || (state == S_WAIT && cnt == 4'd1);
  assign ram_wbe = (go_resp && eff_we && err_code == ERR_NONE) ? eff_be : '0;
  assign ram_re  = go_resp && !eff_we && err_code == ERR_NONE;

  mem_word_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .addr (off[DEPTH_LOG2+1:2]),
    .wbe  (ram_wbe),
    .wdata(eff_wdata),
    .re   (ram_re),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      load_q    <= 1'b0;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_be    <= '0;
      lat_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_be    <= req_be;
            lat_wdata <= req_wdata;
            cnt       <= WAIT_INIT;
            req_ready <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: cnt <= cnt - 4'd1;
        S_RESP: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          load_q    <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
      if (go_resp) begin
        state     <= S_RESP;
        rsp_valid <= 1'b1;
        rsp_err   <= (err_code != ERR_NONE);
        load_q    <= ram_re;
      end
    end
  end

  // Read data is gated so it is zero outside the response pulse and for stores/errors.
  assign rsp_rdata = load_q ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: vector table, corner-case sequences, random vs model.
module tb_mem_responder;

  localparam int unsigned WAITC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, rsp_valid, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;
  logic        r0_valid, r0_ready, r0_we, r0_rsp_valid, r0_rsp_err;
  logic [31:0] r0_addr, r0_wdata, r0_rsp_rdata;
  logic [3:0]  r0_be;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(WAITC), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

  mem_responder #(.DEPTH_LOG2(4), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_1000)) dut0 (
    .clk(clk), .reset(reset), .req_valid(r0_valid), .req_ready(r0_ready), .req_we(r0_we),
    .req_addr(r0_addr), .req_be(r0_be), .req_wdata(r0_wdata), .rsp_valid(r0_rsp_valid),
    .rsp_rdata(r0_rsp_rdata), .rsp_err(r0_rsp_err));

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vt [16];
  logic [31:0] model_mem [256];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic txn(input string nm, input logic we, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wd, input logic eerr, input logic [31:0] erd);
    int guard, lat, rdy_hi;
    req_we = we; req_addr = addr; req_be = be; req_wdata = wd; req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin tick(); guard++; end
    tick();
    req_valid = 1'b0; req_we = ~we; req_addr = $urandom; req_be = 4'($urandom); req_wdata = $urandom;
    lat = 0; rdy_hi = 0;
    while (!rsp_valid && lat < 40) begin
      if (req_ready) rdy_hi++;
      tick();
      lat++;
    end
    if (req_ready) rdy_hi++;
    check({nm, "_lat"}, 32'(lat), WAITC);
    check({nm, "_busy_ready"}, 32'(rdy_hi), 32'd0);
    check({nm, "_err"}, {31'b0, rsp_err}, {31'b0, eerr});
    check({nm, "_rdata"}, rsp_rdata, erd);
    tick();
    check({nm, "_idle"}, {30'b0, rsp_valid, req_ready}, 32'h1);
  endtask

  task automatic txn0(input string nm, input logic we, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wd, input logic eerr, input logic [31:0] erd);
    int guard;
    r0_we = we; r0_addr = addr; r0_be = be; r0_wdata = wd; r0_valid = 1'b1;
    guard = 0;
    while (!r0_ready && guard < 20) begin tick(); guard++; end
    tick();
    r0_valid = 1'b0; r0_we = ~we; r0_addr = $urandom; r0_wdata = $urandom;
    check({nm, "_resp_now"}, {30'b0, r0_rsp_valid, r0_ready}, 32'h2);
    check({nm, "_err"}, {31'b0, r0_rsp_err}, {31'b0, eerr});
    check({nm, "_rdata"}, r0_rsp_rdata, erd);
    tick();
    check({nm, "_idle"}, {30'b0, r0_rsp_valid, r0_ready}, 32'h1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, pulses, wide, ready_bad, last_acc, nresp;
    logic busy, prev_v, acc_now;

    reset = 1'b0;
    req_valid = 0; req_we = 0; req_addr = 0; req_be = 0; req_wdata = 0;
    r0_valid = 0; r0_we = 0; r0_addr = 0; r0_be = 0; r0_wdata = 0;
    tick(); tick();
    check("reset_outputs", {28'b0, req_ready, rsp_valid, rsp_err, r0_ready}, 32'h9);
    check("reset_rdata", rsp_rdata, 32'h0);
    @(negedge clk) reset = 1'b1;
    tick();

    vt[0]  = '{1'b1, 32'h10,  4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vt[1]  = '{1'b0, 32'h10,  4'h0, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vt[2]  = '{1'b1, 32'h10,  4'h2, 32'h0000_5500, 1'b0, 32'h0};
    vt[3]  = '{1'b0, 32'h10,  4'hF, 32'hFFFF_FFFF, 1'b0, 32'hDEAD_55EF};
    vt[4]  = '{1'b1, 32'h0,   4'hF, 32'hCAFE_F00D, 1'b0, 32'h0};
    vt[5]  = '{1'b0, 32'h12,  4'hF, 32'h0,         1'b1, 32'h0};
    vt[6]  = '{1'b1, 32'h400, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0};
    vt[7]  = '{1'b0, 32'h0,   4'h0, 32'h0,         1'b0, 32'hCAFE_F00D};
    vt[8]  = '{1'b1, 32'h3FC, 4'hF, 32'h0BAD_C0DE, 1'b0, 32'h0};
    vt[9]  = '{1'b1, 32'h3FC, 4'h0, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vt[10] = '{1'b0, 32'h3FC, 4'h0, 32'h0,         1'b0, 32'h0BAD_C0DE};
    vt[11] = '{1'b0, 32'h400, 4'h0, 32'h0,         1'b1, 32'h0};
    vt[12] = '{1'b1, 32'h20,  4'hF, 32'h1111_2222, 1'b0, 32'h0};
    vt[13] = '{1'b0, 32'h20,  4'h0, 32'h0,         1'b0, 32'h1111_2222};
    vt[14] = '{1'b1, 32'h3FE, 4'hF, 32'h5555_5555, 1'b1, 32'h0};
    vt[15] = '{1'b0, 32'h3FC, 4'h0, 32'h0,         1'b0, 32'h0BAD_C0DE};
    for (int i = 0; i < 16; i++)
      txn($sformatf("vec%0d", i), vt[i].we, vt[i].addr, vt[i].be, vt[i].wdata, vt[i].exp_err, vt[i].exp_rdata);

    // Back-to-back loads with req_valid held high.
    req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0; req_valid = 1'b1;
    acc = 0; pulses = 0; wide = 0; ready_bad = 0; last_acc = 0; busy = 1'b0; prev_v = 1'b0;
    for (int c = 0; c < 40 && pulses < 3; c++) begin
      acc_now = req_valid && req_ready;
      if (busy && req_ready) ready_bad++;
      if (rsp_valid) begin
        pulses++;
        busy = 1'b0;
        check($sformatf("hs_rdata%0d", pulses), rsp_rdata, 32'hDEAD_55EF);
      end
      if (rsp_valid && prev_v) wide++;
      prev_v = rsp_valid;
      if (acc_now) begin
        if (acc > 0) check($sformatf("hs_interval%0d", acc), 32'(c - last_acc), 32'd4);
        last_acc = c;
        acc++;
      end
      tick();
      if (acc_now) begin
        busy = 1'b1;
        if (acc == 3) req_valid = 1'b0;
      end
    end
    check("hs_accepts", 32'(acc), 32'd3);
    check("hs_pulses", 32'(pulses), 32'd3);
    check("hs_ready_low", 32'(ready_bad), 32'd0);
    check("hs_pulse_wide", 32'(wide | {31'b0, rsp_valid}), 32'd0);
    tick();
    check("hs_idle", {30'b0, rsp_valid, req_ready}, 32'h1);

    // Reset during WAIT of a store: no write, no response.
    req_we = 1'b1; req_addr = 32'h20; req_be = 4'hF; req_wdata = 32'h1234_5678; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    #2 reset = 1'b0;
    #1 check("rst_wait_outputs", {30'b0, req_ready, rsp_valid}, 32'h2);
    @(negedge clk) reset = 1'b1;
    nresp = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (rsp_valid) nresp++;
    end
    check("rst_wait_no_rsp", 32'(nresp), 32'd0);
    txn("rst_wait_reload", 1'b0, 32'h20, 4'h0, 32'h0, 1'b0, 32'h1111_2222);

    // Reset while in RESP drops rsp_valid immediately.
    req_we = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    check("rst_resp_pre", {31'b0, rsp_valid}, 32'h1);
    #2 reset = 1'b0;
    #1 check("rst_resp_valid", {31'b0, rsp_valid}, 32'h0);
    check("rst_resp_rdata", rsp_rdata, 32'h0);
    @(negedge clk) reset = 1'b1;
    tick();
    check("rst_resp_ready", {31'b0, req_ready}, 32'h1);

    // Zero-wait build, base 0x1000, 16 words.
    txn0("w0_st", 1'b1, 32'h1010, 4'hF, 32'hA5A5_5A5A, 1'b0, 32'h0);
    txn0("w0_ld", 1'b0, 32'h1010, 4'h0, 32'h0,         1'b0, 32'hA5A5_5A5A);
    txn0("w0_st_top", 1'b1, 32'h103C, 4'hF, 32'h0123_4567, 1'b0, 32'h0);
    txn0("w0_st_below", 1'b1, 32'h0FFC, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0);
    txn0("w0_st_above", 1'b1, 32'h1040, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0);
    txn0("w0_ld_top", 1'b0, 32'h103C, 4'h0, 32'h0,        1'b0, 32'h0123_4567);
    txn0("w0_ld_mis", 1'b0, 32'h1011, 4'h0, 32'h0,        1'b1, 32'h0);

    // Random traffic against a word-array model over 16 pre-initialised words.
    for (int k = 0; k < 16; k++) begin
      int unsigned idx;
      idx = (k < 8) ? k : 240 + k;
      model_mem[idx] = $urandom;
      txn($sformatf("rinit%0d", k), 1'b1, idx * 4, 4'hF, model_mem[idx], 1'b0, 32'h0);
    end
    for (int n = 0; n < 80; n++) begin
      int unsigned k, idx, sel;
      logic        we, eerr;
      logic [31:0] addr, wd, erd;
      logic [3:0]  be;
      k = $urandom_range(0, 15);
      idx = (k < 8) ? k : 240 + k;
      addr = idx * 4;
      sel = $urandom_range(0, 9);
      if (sel == 0) addr = addr + $urandom_range(1, 3);
      else if (sel == 1) addr = 32'h400 | ($urandom & 32'h7FFF_FFFC);
      we = 1'($urandom_range(0, 1));
      be = 4'($urandom);
      wd = $urandom;
      eerr = (addr % 4 != 0) || (addr >= 32'd1024);
      if (!eerr && we)
        for (int b = 0; b < 4; b++)
          if (be[b]) model_mem[addr / 4][8*b +: 8] = wd[8*b +: 8];
      erd = (!eerr && !we) ? model_mem[addr / 4] : 32'h0;
      txn($sformatf("rnd%0d", n), we, addr, be, wd, eerr, erd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-organised data-memory responder: the target end of the multicycle CPU's load/store interface.
- Accepts one request at a time over a valid/ready handshake and inserts a configurable number of wait states.
- Returns one response pulse carrying read data or an error flag.
- Replaces the zero-latency data memory so the CPU control FSM must honour real memory stalls.

Parameters:
- DEPTH_LOG2, 8: memory holds 2**DEPTH_LOG2 32-bit words.
- WAIT_CYCLES, 2: wait-state cycles between accept and response; legal range 0..15.
- BASE_ADDR, 32'h0000_0000: byte address of word 0. Addresses outside [BASE_ADDR, BASE_ADDR + 4*2**DEPTH_LOG2) are errors.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  CPU presents a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_be  input  4  byte enables for stores; bit i enables wdata[8i+7:8i]; ignored for loads.
- req_wdata  input  32  store data.
- rsp_valid  output  1  single-cycle response pulse.
- rsp_rdata  output  32  load data; 0 for stores and on errors.
- rsp_err  output  1  misaligned or out-of-range access; qualified by rsp_valid.

Behaviour:
- Reset (reset == 0, asynchronous): state IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait counter = 0.
  - Memory contents are not cleared; they persist across reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready at a clock edge, latch we, addr, be and wdata, and load counter = WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES > 0, else RESP.
- WAIT:
  - req_ready = 0.
  - Counter decrements each cycle; at the edge where it reaches 1, go to RESP.
  - Exactly WAIT_CYCLES cycles are spent in WAIT.
- RESP:
  - req_ready = 0, rsp_valid = 1 for exactly one cycle, then IDLE.
  - No response backpressure; the CPU must sample rsp_valid in that cycle.
- Latency: rsp_valid is asserted WAIT_CYCLES+1 cycles after the accept edge.
  - The earliest next accept is the cycle after RESP, so the minimum issue interval is WAIT_CYCLES+2 cycles.
- Error check (on latched request): rsp_err = 1 if addr[1:0] != 0 or addr is out of range.
  - An errored store writes nothing; an errored load returns rsp_rdata = 0.
- Store commit:
  - Happens at the edge entering RESP.
  - Only enabled bytes are written; be = 4'b0000 is a legal no-op store with rsp_err = 0.
  - rsp_rdata = 0 for stores.
- Load data:
  - Registered at the edge entering RESP; rsp_rdata is valid only while rsp_valid = 1 and is 0 otherwise.
  - A load issued after a completed store to the same word returns the stored bytes.
- Word index = (addr - BASE_ADDR) >> 2, truncated to DEPTH_LOG2 bits after the range check.
- req_valid while req_ready = 0 is ignored; the request is not queued and the CPU must hold it.
- Reset mid-operation:
  - A transaction in WAIT is dropped with no write and no response.
  - Reset asserted in RESP forces rsp_valid low immediately.
- Input changes after the accept edge have no effect on the in-flight transaction.

Decomposition:
- Shared package (cpu_mem_pkg):
  - FSM state encoding (IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2).
  - Byte-enable width constant BE_W = 4 and word width constant WORD_W = 32.
  - Error-code localparams for future extension.
- Sub-module mem_word_array:
  - Byte-enabled synchronous-write RAM with a registered read port, 2**DEPTH_LOG2 x 32.
  - No reset on the array.
  - The responder FSM, counter, address check and response registers stay in mem_responder.

Test Plan:
- WAIT_CYCLES=2: store addr 32'h10, be 4'hF, wdata 32'hDEAD_BEEF; then load addr 32'h10.
  - Store gets rsp_valid 3 cycles after accept with rsp_err = 0.
  - Load returns rsp_rdata 32'hDEAD_BEEF, 3 cycles after its accept.
- Partial store: addr 32'h10, be 4'b0010, wdata 32'h0000_5500 over 32'hDEAD_BEEF.
  - Following load returns 32'hDEAD_55EF.
- Errors: load addr 32'h12 and store addr 32'h400 with DEPTH_LOG2=8.
  - Both get rsp_err = 1 and rsp_rdata = 0.
  - A load of 32'h0 afterwards still returns its prior contents, showing the errored store did not corrupt word 0.
- Handshake: hold req_valid high continuously with 3 back-to-back loads.
  - req_ready is low from accept through RESP.
  - Accepts occur every 4 cycles; exactly 3 rsp_valid pulses, each 1 cycle wide.
- WAIT_CYCLES=0 build: load accepted at edge N.
  - rsp_valid is high in cycle N+1, then req_ready is high in cycle N+2.
- Reset mid-operation: pull reset low during WAIT of a store to 32'h20 (wdata 32'h1234_5678), then release.
  - req_ready = 1, no rsp_valid pulse.
  - A subsequent load of 32'h20 returns the pre-store value, with memory contents retained.
